// File: rtl/vicii_mem_arbiter.sv
// VIC-II fetch arbiter: sprite/graphics address select, registered read return and CPU BA/AEC handshake.
// Optional sticky data-fetch-before-ownership detector enabled by `define VICII_BA_VIOLATION_EN.
module vicii_mem_arbiter #(
    parameter int NSPR    = 8,
    parameter int BA_LEAD = 6,
    parameter int AW      = 14
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NSPR*AW-1:0]  i_spr_ao,
    input  logic [NSPR-1:0]     i_spr_ba,
    input  logic [AW-1:0]       i_g_ao,
    output logic [AW-1:0]       o_mem_a,
    input  logic [7:0]          i_mem_d,
    output logic [7:0]          o_di,
    output logic [3:0]          o_src,
    output logic                o_cpu_ba,
    output logic                o_aec,
    output logic                o_ba_violation
);

    localparam int CW = $clog2(BA_LEAD + 1);
    localparam logic [CW-1:0] LEAD_MAX = CW'(BA_LEAD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LEAD = 2'd1,
        S_OWN  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            r_cpu_ba;
    logic            r_aec;
    logic            w_cpu_ba_nxt;
    logic            w_aec_nxt;
    logic [7:0]      r_di;
    logic [3:0]      r_src;
    logic [3:0]      w_sel_idx;
    logic [AW-1:0]   w_sel_ao;
    logic            w_any_req;

    assign w_any_req = |i_spr_ba;

    // Address select: descending scan so the lowest non-idle sprite wins, graphics otherwise.
    always_comb begin
        w_sel_idx = 4'hF;
        w_sel_ao  = i_g_ao;
        for (int n = NSPR - 1; n >= 0; n--) begin
            if (i_spr_ao[n*AW +: AW] != {AW{1'b0}}) begin
                w_sel_idx = 4'(n);
                w_sel_ao  = i_spr_ao[n*AW +: AW];
            end else begin
                w_sel_idx = w_sel_idx;
            end
        end
    end

    assign o_mem_a = w_sel_ao;

    // Read return register: data and its source captured every cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_di  <= 8'h00;
            r_src <= 4'hF;
        end else begin
            r_di  <= i_mem_d;
            r_src <= w_sel_idx;
        end
    end

    // FSM state, lead counter and handshake output registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= {CW{1'b0}};
            r_cpu_ba <= 1'b1;
            r_aec    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_cpu_ba <= w_cpu_ba_nxt;
            r_aec    <= w_aec_nxt;
        end
    end

    // Next-state logic; a dropped request during LEAD abandons the lead entirely.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_LEAD;
                    w_cnt_nxt   = {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    w_cnt_nxt   = {CW{1'b0}};
                end
            end
            S_LEAD: begin
                if (!w_any_req) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = {CW{1'b0}};
                end else if (r_cnt == LEAD_MAX) begin
                    w_state_nxt = S_OWN;
                end else begin
                    w_cnt_nxt   = r_cnt + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_OWN: begin
                if (!w_any_req) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = {CW{1'b0}};
                end else begin
                    w_state_nxt = S_OWN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = {CW{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so cpu_ba/aec leave flops.
    always_comb begin
        w_cpu_ba_nxt = 1'b1;
        w_aec_nxt    = 1'b0;
        case (w_state_nxt)
            S_IDLE: begin
                w_cpu_ba_nxt = 1'b1;
                w_aec_nxt    = 1'b0;
            end
            S_LEAD: begin
                w_cpu_ba_nxt = 1'b0;
                w_aec_nxt    = 1'b0;
            end
            S_OWN: begin
                w_cpu_ba_nxt = 1'b0;
                w_aec_nxt    = 1'b1;
            end
            default: begin
                w_cpu_ba_nxt = 1'b1;
                w_aec_nxt    = 1'b0;
            end
        endcase
    end

    assign o_di     = r_di;
    assign o_src    = r_src;
    assign o_cpu_ba = r_cpu_ba;
    assign o_aec    = r_aec;

`ifdef VICII_BA_VIOLATION_EN
    logic w_sel_ba;
    logic w_ptr_fetch;
    logic w_viol_hit;
    logic r_ba_violation;

    // Bus request bit of the currently selected sprite.
    always_comb begin
        w_sel_ba = 1'b0;
        for (int n = 0; n < NSPR; n++) begin
            if (w_sel_idx == 4'(n)) begin
                w_sel_ba = i_spr_ba[n];
            end else begin
                w_sel_ba = w_sel_ba;
            end
        end
    end

    assign w_ptr_fetch = (w_sel_ao[2:0] == w_sel_idx[2:0]) && (w_sel_ao[9:3] == 7'h7F);
    assign w_viol_hit  = (w_sel_idx != 4'hF) && w_sel_ba && !w_ptr_fetch && !r_aec;

    // Sticky flag: a sprite data fetch was issued before the VIC owned the bus.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ba_violation <= 1'b0;
        end else if (w_viol_hit) begin
            r_ba_violation <= 1'b1;
        end else begin
            r_ba_violation <= r_ba_violation;
        end
    end

    assign o_ba_violation = r_ba_violation;
`else
    assign o_ba_violation = 1'b0;
`endif

endmodule

// File: tb/tb_vicii_mem_arbiter.sv
// Directed, table-driven bench for vicii_mem_arbiter (NSPR=8, BA_LEAD=6, AW=14).
module tb_vicii_mem_arbiter;

    localparam int NSPR    = 8;
    localparam int BA_LEAD = 6;
    localparam int AW      = 14;

    logic                i_clk;
    logic                i_reset;
    logic [NSPR*AW-1:0]  i_spr_ao;
    logic [NSPR-1:0]     i_spr_ba;
    logic [AW-1:0]       i_g_ao;
    logic [AW-1:0]       o_mem_a;
    logic [7:0]          i_mem_d;
    logic [7:0]          o_di;
    logic [3:0]          o_src;
    logic                o_cpu_ba;
    logic                o_aec;
    logic                o_ba_violation;

    int checks;
    int errors;
    logic exp_viol;

    typedef struct {
        logic [NSPR*AW-1:0] ao;
        logic [AW-1:0]      g;
        logic [7:0]         d;
        logic [AW-1:0]      ea;
        logic [7:0]         ed;
        logic [3:0]         es;
    } vec_t;

    vec_t vecs[6];

    vicii_mem_arbiter #(.NSPR(NSPR), .BA_LEAD(BA_LEAD), .AW(AW)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_spr_ao       (i_spr_ao),
        .i_spr_ba       (i_spr_ba),
        .i_g_ao         (i_g_ao),
        .o_mem_a        (o_mem_a),
        .i_mem_d        (i_mem_d),
        .o_di           (o_di),
        .o_src          (o_src),
        .o_cpu_ba       (o_cpu_ba),
        .o_aec          (o_aec),
        .o_ba_violation (o_ba_violation)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [NSPR*AW-1:0] spr(input int n, input logic [AW-1:0] v);
        logic [NSPR*AW-1:0] r;
        r = '0;
        r[n*AW +: AW] = v;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Counts clocks from cpu_ba falling until aec rises; expects exactly BA_LEAD.
    task automatic wait_own();
        int k;
        k = 0;
        for (int i = 1; i <= BA_LEAD + 4; i++) begin
            @(posedge i_clk);
            #1;
            if (o_aec === 1'b1) begin
                k = i;
                break;
            end
        end
        chk("lead_len", k, BA_LEAD);
        chk("own_cpu_ba", o_cpu_ba, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
`ifdef VICII_BA_VIOLATION_EN
        exp_viol = 1'b1;
`else
        exp_viol = 1'b0;
`endif
        vecs[0] = '{ao: '0, g: 14'h0400, d: 8'h5A, ea: 14'h0400, ed: 8'h5A, es: 4'hF};
        vecs[1] = '{ao: spr(1, 14'h1F81) | spr(5, 14'h2003), g: 14'h0400, d: 8'h33,
                    ea: 14'h1F81, ed: 8'h33, es: 4'h1};
        vecs[2] = '{ao: spr(5, 14'h2003), g: 14'h0400, d: 8'h44, ea: 14'h2003, ed: 8'h44, es: 4'h5};
        vecs[3] = '{ao: spr(0, 14'h0001) | spr(7, 14'h3FFF), g: 14'h0123, d: 8'h01,
                    ea: 14'h0001, ed: 8'h01, es: 4'h0};
        vecs[4] = '{ao: spr(7, 14'h3FFF), g: 14'h1234, d: 8'hFF, ea: 14'h3FFF, ed: 8'hFF, es: 4'h7};
        vecs[5] = '{ao: '0, g: 14'h3FFF, d: 8'h00, ea: 14'h3FFF, ed: 8'h00, es: 4'hF};

        i_reset  = 1'b1;
        i_spr_ao = '0;
        i_spr_ba = '0;
        i_g_ao   = 14'h0400;
        i_mem_d  = 8'h5A;
        #12;
        chk("rst_di", o_di, 8'h00);
        chk("rst_src", o_src, 4'hF);
        chk("rst_cpu_ba", o_cpu_ba, 1'b1);
        chk("rst_aec", o_aec, 1'b0);
        chk("rst_viol", o_ba_violation, 1'b0);
        @(negedge i_clk);
        i_reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            @(negedge i_clk);
            i_spr_ao = vecs[v].ao;
            i_g_ao   = vecs[v].g;
            i_mem_d  = vecs[v].d;
            #1;
            chk($sformatf("v%0d_mem_a", v), o_mem_a, vecs[v].ea);
            @(posedge i_clk);
            #1;
            chk($sformatf("v%0d_di", v), o_di, vecs[v].ed);
            chk($sformatf("v%0d_src", v), o_src, vecs[v].es);
            chk($sformatf("v%0d_cpu_ba", v), o_cpu_ba, 1'b1);
            chk($sformatf("v%0d_aec", v), o_aec, 1'b0);
        end

        // Full lead for sprite 2, then release.
        @(negedge i_clk);
        i_spr_ao = '0;
        i_spr_ba = 8'b0000_0100;
        @(posedge i_clk);
        #1;
        chk("s2_cpu_ba_fall", o_cpu_ba, 1'b0);
        chk("s2_aec_lead", o_aec, 1'b0);
        wait_own();
        @(negedge i_clk);
        i_spr_ba = '0;
        @(posedge i_clk);
        #1;
        chk("s2_rel_cpu_ba", o_cpu_ba, 1'b1);
        chk("s2_rel_aec", o_aec, 1'b0);

        // Back-to-back: request again on the edge right after release.
        @(negedge i_clk);
        i_spr_ba = 8'b0000_0100;
        @(posedge i_clk);
        #1;
        chk("b2b_cpu_ba", o_cpu_ba, 1'b0);
        wait_own();
        @(negedge i_clk);
        i_spr_ba = '0;
        @(posedge i_clk);
        #1;

        // Short pulse on sprite 0: lead abandoned, no ownership.
        @(negedge i_clk);
        i_spr_ba = 8'b0000_0001;
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk);
            #1;
            chk($sformatf("pulse_aec%0d", i), o_aec, 1'b0);
            chk($sformatf("pulse_cpu_ba%0d", i), o_cpu_ba, 1'b0);
        end
        @(negedge i_clk);
        i_spr_ba = '0;
        @(posedge i_clk);
        #1;
        chk("pulse_drop_cpu_ba", o_cpu_ba, 1'b1);
        chk("pulse_drop_aec", o_aec, 1'b0);
        @(negedge i_clk);
        i_spr_ba = 8'b0000_0001;
        @(posedge i_clk);
        #1;
        chk("restart_cpu_ba", o_cpu_ba, 1'b0);
        wait_own();

        // Asynchronous reset while owning the bus, off the clock edge.
        i_mem_d = 8'hA5;
        @(posedge i_clk);
        #1;
        chk("own_di", o_di, 8'hA5);
        #2;
        i_reset = 1'b1;
        #1;
        chk("arst_cpu_ba", o_cpu_ba, 1'b1);
        chk("arst_aec", o_aec, 1'b0);
        chk("arst_di", o_di, 8'h00);
        chk("arst_src", o_src, 4'hF);
        @(negedge i_clk);
        i_reset  = 1'b0;
        i_spr_ba = '0;
        @(posedge i_clk);
        #1;
        chk("post_rst_cpu_ba", o_cpu_ba, 1'b1);

        // Sprite 3 data fetch while aec is low.
        @(negedge i_clk);
        i_spr_ao = spr(3, 14'h2A05);
        i_spr_ba = 8'b0000_1000;
        #1;
        chk("viol_mem_a", o_mem_a, 14'h2A05);
        chk("viol_pre", o_ba_violation, 1'b0);
        @(posedge i_clk);
        #1;
        chk("viol_set", o_ba_violation, exp_viol);
        chk("viol_src", o_src, 4'h3);
        @(negedge i_clk);
        i_spr_ao = '0;
        i_spr_ba = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("viol_sticky", o_ba_violation, exp_viol);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
